// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer.
//   state_t        - controller states IDLE / RUN / PAUSE (done and load_err
//                    are output pulses, not states)
//   BCD9, BCD5     - largest value of a units digit and of a tens digit
//   preset_legal() - true when all four preset digits form a valid MM:SS value
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [3:0] BCD9 = 4'd9;
  localparam logic [3:0] BCD5 = 4'd5;

  function automatic logic preset_legal(input logic [3:0] mh,
                                        input logic [3:0] ml,
                                        input logic [3:0] sh,
                                        input logic [3:0] sl);
    return (mh <= BCD5) && (ml <= BCD9) && (sh <= BCD5) && (sl <= BCD9);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counting borrow chain (purely combinational).
//   digit      - current digit value
//   borrow_in  - decrement request from the less significant stage
//   result     - digit after the optional decrement
//   borrow_out - set when the digit wrapped from 0 to MAX
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] result,
  output logic       borrow_out
);

  always_comb begin
    result     = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        result     = MAX;
        borrow_out = 1'b1;
      end else begin
        result = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer, decrementing once every TICK_DIV clk cycles.
//   clk                       - system clock, rising edge
//   reset                     - asynchronous, active-low
//   load, ld_mh/ld_ml/ld_sh/ld_sl - preset request and BCD preset digits
//   start, pause, clear       - control pulses (priority clear > load > pause > start)
//   MH, ML, SH, SL            - registered BCD count digits
//   running                   - high while counting
//   done                      - one-cycle pulse when the count reaches 00:00
//   load_err                  - one-cycle pulse after a rejected preset
module countdown_timer #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_mh,
  input  logic [3:0] ld_ml,
  input  logic [3:0] ld_sh,
  input  logic [3:0] ld_sl,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] MH,
  output logic [3:0] ML,
  output logic [3:0] SH,
  output logic [3:0] SL,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  import timer_pkg::*;

  localparam int unsigned     PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

  state_t          state, state_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [3:0]      mh_nxt, ml_nxt, sh_nxt, sl_nxt;
  logic            done_nxt, err_nxt;

  logic            tick;
  logic            b_sl, b_sh, b_ml, b_mh;
  logic [3:0]      dec_mh, dec_ml, dec_sh, dec_sl;
  logic            count_nz;

  assign tick     = (state == RUN) && (presc == PRE_LAST);
  assign count_nz = |{MH, ML, SH, SL};

  bcd_down_digit #(.MAX(BCD9)) u_sl (.digit(SL), .borrow_in(tick), .result(dec_sl), .borrow_out(b_sl));
  bcd_down_digit #(.MAX(BCD5)) u_sh (.digit(SH), .borrow_in(b_sl), .result(dec_sh), .borrow_out(b_sh));
  bcd_down_digit #(.MAX(BCD9)) u_ml (.digit(ML), .borrow_in(b_sh), .result(dec_ml), .borrow_out(b_ml));
  bcd_down_digit #(.MAX(BCD5)) u_mh (.digit(MH), .borrow_in(b_ml), .result(dec_mh), .borrow_out(b_mh));

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    mh_nxt    = MH;
    ml_nxt    = ML;
    sh_nxt    = SH;
    sl_nxt    = SL;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    if (clear) begin
      state_nxt = IDLE;
      presc_nxt = '0;
      mh_nxt    = '0;
      ml_nxt    = '0;
      sh_nxt    = '0;
      sl_nxt    = '0;
    end else if (load && (state != RUN)) begin
      // A load while counting is dropped entirely, so pause/start still apply.
      if (preset_legal(ld_mh, ld_ml, ld_sh, ld_sl)) begin
        state_nxt = IDLE;
        presc_nxt = '0;
        mh_nxt    = ld_mh;
        ml_nxt    = ld_ml;
        sh_nxt    = ld_sh;
        sl_nxt    = ld_sl;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (pause && (state == RUN)) begin
      state_nxt = PAUSE;
    end else if (start && (state != RUN) && count_nz) begin
      state_nxt = RUN;
      if (state == IDLE) presc_nxt = '0;
    end else if (state == RUN) begin
      if (tick) begin
        presc_nxt = '0;
        // A borrow out of the tens-of-minutes digit would mean 00:00 wrapping.
        if (!b_mh) begin
          mh_nxt = dec_mh;
          ml_nxt = dec_ml;
          sh_nxt = dec_sh;
          sl_nxt = dec_sl;
          if ({dec_mh, dec_ml, dec_sh, dec_sl} == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      presc    <= '0;
      MH       <= '0;
      ML       <= '0;
      SH       <= '0;
      SL       <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      MH       <= mh_nxt;
      ML       <= ml_nxt;
      SH       <= sh_nxt;
      SL       <= sl_nxt;
      running  <= (state_nxt == RUN);
      done     <= done_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with TICK_DIV=4: directed scenarios
// followed by random control pulses, all compared against a seconds-based model.
module tb_countdown_timer;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load, start, pause, clear;
  logic [3:0] ld_mh, ld_ml, ld_sh, ld_sl;
  logic [3:0] MH, ML, SH, SL;
  logic       running, done, load_err;

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .load(load),
    .ld_mh(ld_mh), .ld_ml(ld_ml), .ld_sh(ld_sh), .ld_sl(ld_sl),
    .start(start), .pause(pause), .clear(clear),
    .MH(MH), .ML(ML), .SH(SH), .SL(SL),
    .running(running), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Reference model: count held as a number of seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int m_state, m_secs, m_presc;
  bit m_done, m_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int s);
    int m, sec;
    m   = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {MH, ML, SH, SL};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_secs = 0; m_presc = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    m_err  = 0;
    if (clear) begin
      m_state = M_IDLE; m_secs = 0; m_presc = 0;
    end else if (load && m_state != M_RUN) begin
      if (ld_mh <= 5 && ld_ml <= 9 && ld_sh <= 5 && ld_sl <= 9) begin
        m_secs  = (int'(ld_mh) * 10 + int'(ld_ml)) * 60 + int'(ld_sh) * 10 + int'(ld_sl);
        m_presc = 0;
        m_state = M_IDLE;
      end else begin
        m_err = 1;
      end
    end else if (pause && m_state == M_RUN) begin
      m_state = M_PAUSE;
    end else if (start && m_state != M_RUN && m_secs > 0) begin
      if (m_state == M_IDLE) m_presc = 0;
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (m_presc == TD - 1) begin
        m_presc = 0;
        m_secs--;
        if (m_secs == 0) begin
          m_state = M_IDLE;
          m_done  = 1;
        end
      end else begin
        m_presc++;
      end
    end
  endtask

  // One clock: model follows the inputs seen at the edge, outputs checked #1 later,
  // then the single-cycle inputs are dropped.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
    check("digits",   32'(digits()),  32'(bcd_of(m_secs)));
    check("running",  32'(running),   32'(m_state == M_RUN));
    check("done",     32'(done),      32'(m_done));
    check("load_err", 32'(load_err),  32'(m_err));
    load = 0; start = 0; pause = 0; clear = 0;
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    ld_mh = a; ld_ml = b; ld_sh = c; ld_sl = d; load = 1;
    cycle();
  endtask

  initial begin
    int done_at;
    reset = 0; load = 0; start = 0; pause = 0; clear = 0;
    ld_mh = 0; ld_ml = 0; ld_sh = 0; ld_sl = 0;
    model_reset();

    // Reset state before any clock edge
    #3;
    check("rst_digits", 32'(digits()), 32'h0);
    check("rst_flags",  32'({running, done, load_err}), 32'h0);
    cycle(); cycle();
    reset = 1;
    cycle();

    // 01:05 countdown to done
    do_load(4'd0, 4'd1, 4'd0, 4'd5);
    start = 1;
    cycle();
    done_at = -1;
    for (int k = 1; k <= 300; k++) begin
      cycle();
      if (k == 4)  check("d_0104", 32'(digits()), 32'h0104);
      if (k == 24) check("d_0059", 32'(digits()), 32'h0059);
      if (done && done_at < 0) done_at = k;
      if (done_at >= 0 && k >= done_at + 2) break;
    end
    check("done_at", 32'(done_at), 32'd260);
    check("run_after_done", 32'(running), 32'd0);

    // Illegal presets in IDLE and in PAUSE
    do_load(4'd0, 4'd1, 4'd0, 4'd5);
    do_load(4'd0, 4'd1, 4'd0, 4'hA);
    check("lerr_sl", 32'(load_err), 32'd1);
    check("keep_sl", 32'(digits()), 32'h0105);
    cycle();
    do_load(4'd0, 4'd1, 4'd6, 4'd0);
    check("lerr_sh", 32'(load_err), 32'd1);
    start = 1; cycle();
    cycle(); cycle();
    pause = 1; cycle();
    do_load(4'd9, 4'd0, 4'd0, 4'd0);
    check("lerr_pause", 32'(load_err), 32'd1);
    start = 1; cycle();
    for (int k = 0; k < 6; k++) cycle();

    // Pause 2 cycles into a tick period, resume, next decrement 2 cycles later
    clear = 1; cycle();
    do_load(4'd0, 4'd0, 4'd1, 4'd0);
    start = 1; cycle();
    cycle(); cycle();
    pause = 1; cycle();
    for (int k = 0; k < 20; k++) cycle();
    check("paused_0010", 32'(digits()), 32'h0010);
    start = 1; cycle();
    cycle();
    check("resume_0010", 32'(digits()), 32'h0010);
    cycle();
    check("resume_0009", 32'(digits()), 32'h0009);

    // Start at 00:00 ignored; start+pause while running gives PAUSE
    clear = 1; cycle();
    start = 1; cycle();
    check("start_zero", 32'({running, done}), 32'h0);
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    start = 1; cycle();
    cycle();
    start = 1; pause = 1; cycle();
    check("start_pause", 32'(running), 32'd0);
    cycle(); cycle();

    // Asynchronous reset mid-count at 00:03
    clear = 1; cycle();
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    start = 1; cycle();
    for (int k = 0; k < 8; k++) cycle();
    check("d_0003", 32'(digits()), 32'h0003);
    reset = 0;
    #2;
    check("arst_digits", 32'(digits()), 32'h0);
    check("arst_flags",  32'({running, done, load_err}), 32'h0);
    model_reset();
    cycle(); cycle();
    reset = 1;
    cycle();

    // Clear while running
    do_load(4'd0, 4'd0, 4'd0, 4'd7);
    start = 1; cycle();
    for (int k = 0; k < 5; k++) cycle();
    clear = 1; cycle();
    check("clr_state", 32'({digits(), 2'b00, running, done}), 32'h0);

    // Random control pulses, one command per cycle
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) clear = 1;
      else if (r < 8) begin
        if ($urandom_range(0, 3) != 0) begin
          ld_mh = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 5));
          ld_ml = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 9));
          ld_sh = 4'($urandom_range(0, 5));
          ld_sl = 4'($urandom_range(0, 9));
        end else begin
          ld_mh = 4'($urandom_range(0, 15));
          ld_ml = 4'($urandom_range(0, 15));
          ld_sh = 4'($urandom_range(0, 15));
          ld_sl = 4'($urandom_range(0, 15));
        end
        load = 1;
      end
      else if (r < 11) pause = 1;
      else if (r < 20) start = 1;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, the number of clk cycles per one-second decrement (legal values >= 2).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port load, input, 1, single-cycle request to capture ld_mh/ld_ml/ld_sh/ld_sl.
REQ-005 SHALL have ports ld_mh, ld_ml, ld_sh, ld_sl, input, 4 each, BCD preset digits (minutes tens/ones, seconds tens/ones).
REQ-006 SHALL have port start, input, 1, single-cycle request to begin or resume counting.
REQ-007 SHALL have port pause, input, 1, single-cycle request to suspend counting.
REQ-008 SHALL have port clear, input, 1, synchronous clear to 00:00 and idle.
REQ-009 SHALL have ports MH, ML, SH, SL, output, 4 each, registered BCD count digits.
REQ-010 SHALL have port running, output, 1, high while in state RUN.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when the count reaches 00:00 by decrement.
REQ-012 SHALL have port load_err, output, 1, one-cycle pulse when a load is rejected.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE; done and load_err are pulses, not states.
REQ-014 SHALL apply per-cycle priority: clear > load > pause > start.
REQ-015 clear: digits <- 0, prescaler <- 0, state <- IDLE, from any state; done not asserted.
REQ-016 load in IDLE or PAUSE: accept only if ld_sl<=9, ld_sh<=5, ld_ml<=9, ld_mh<=5; on accept capture digits next cycle, prescaler <- 0, state <- IDLE.
REQ-017 load with any illegal digit: digits and state unchanged, load_err high for exactly the following cycle.
REQ-018 load in RUN: ignored, no load_err.
REQ-019 start in IDLE with nonzero count: state <- RUN, prescaler <- 0; start in PAUSE with nonzero count: state <- RUN, prescaler retained.
REQ-020 start with count 00:00: ignored, state unchanged, done not asserted.
REQ-021 pause in RUN: state <- PAUSE, prescaler and digits frozen; pause in IDLE/PAUSE ignored; start and pause together in RUN: PAUSE.
REQ-022 RUN: prescaler counts 0..TICK_DIV-1 and wraps; on the wrap cycle the count decrements by one second.
REQ-023 Decrement: SL 0->9 borrows from SH; SH 0->5 borrows from ML; ML 0->9 borrows from MH; otherwise digit minus one (e.g. 10:00 -> 09:59).
REQ-024 When a decrement yields 00:00: same edge sets state IDLE, running low, done high for that one cycle while outputs show 00:00; never wraps below 00:00.
REQ-025 First decrement after start from IDLE occurs exactly TICK_DIV cycles after the start cycle.
REQ-026 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-027 While reset low: MH=ML=SH=SL=0, prescaler=0, state IDLE, running=0, done=0, load_err=0, regardless of clk.
REQ-028 Reset asserted mid-RUN SHALL abort counting with no done pulse; after release block is in IDLE awaiting load/start.

Structure
REQ-029 Package timer_pkg SHALL hold the state enumeration and constants BCD9=9, BCD5=5.
REQ-030 Sub-module bcd_down_digit (parameter MAX: decrement with borrow-in/borrow-out and wrap to MAX) SHALL be instantiated four times in a borrow chain.
REQ-031 Prescaler width SHALL be $clog2(TICK_DIV); no other parameters.

Verification (TICK_DIV=4)
REQ-032 load 01:05, start -> 01:04 after 4 cycles; 01:00 -> 00:59; done pulses once at 00:00 exactly 260 cycles after start; running low thereafter.
REQ-033 load with ld_sl=4'hA or ld_sh=6 -> load_err one cycle, digits unchanged, state unchanged.
REQ-034 run 00:10, pause 2 cycles into a tick period, wait 20 cycles, start -> no change while paused; next decrement 2 cycles after resume.
REQ-035 start at 00:00 -> running stays 0, no done; start and pause in same cycle while RUN -> PAUSE.
REQ-036 assert reset mid-RUN at 00:03 -> all outputs 0 immediately, no done; clear during RUN -> 00:00, IDLE, no done.
